// File: rtl/ddr_train_pkg.sv
// Shared types and helpers for the DQS/DQ lane eye trainer.
// Holds the FSM encoding, width derivation and the CENTER_TAP slice offset.
package ddr_train_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StClear,
        StSample,
        StEval,
        StStep,
        StSettle,
        StCenter,
        StCMove,
        StCSettle,
        StFail,
        StNext,
        StFinish
    } state_e;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned calc_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // LSB of a lane's field inside the packed CENTER_TAP vector.
    function automatic int unsigned tap_lsb(input int unsigned lane, input int unsigned tap_w);
        return lane * tap_w;
    endfunction

endpackage

// File: rtl/ddr_eye_tap_sampler.sv
// Per-tap SAMPLE/SETTLE cycle counter with early/late and out-of-range accumulators.
// A start pulse loads the counter for the state that follows; done flags its last cycle.
module ddr_eye_tap_sampler
    import ddr_train_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned LANE_W        = 1,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLE_CYCLES = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_mode_sample,
    input  logic                 i_sample_en,
    input  logic [LANE_W-1:0]    i_lane,
    input  logic [NUM_LANES-1:0] i_early,
    input  logic [NUM_LANES-1:0] i_late,
    input  logic [NUM_LANES-1:0] i_oor,
    output logic                 o_done,
    output logic                 o_fail_acc,
    output logic                 o_oor_acc
);

    localparam int unsigned MAX_CNT = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES
                                                                      : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = calc_w(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] SAMPLE_INIT = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_fail_acc;
    logic             r_oor_acc;
    logic             w_fail_now;
    logic             w_oor_now;

    assign w_fail_now = i_early[i_lane] | i_late[i_lane];
    assign w_oor_now  = i_oor[i_lane];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_fail_acc <= 1'b0;
            r_oor_acc  <= 1'b0;
        end else begin
            if (i_start) begin
                r_cnt <= i_mode_sample ? SAMPLE_INIT : SETTLE_INIT;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (i_start && i_mode_sample) begin
                r_fail_acc <= 1'b0;
                r_oor_acc  <= 1'b0;
            end else if (i_sample_en) begin
                r_fail_acc <= r_fail_acc | w_fail_now;
                r_oor_acc  <= r_oor_acc | w_oor_now;
            end
        end
    end

    assign o_done     = (r_cnt == '0);
    assign o_fail_acc = r_fail_acc;
    assign o_oor_acc  = r_oor_acc;

endmodule

// File: rtl/ddr_dqs_lane_eye_trainer.sv
// Sequential per-lane delay-line sweep that finds the passing eye window and parks
// each lane's line at the window centre.
module ddr_dqs_lane_eye_trainer
    import ddr_train_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned MAX_TAPS      = 128,
    parameter int unsigned TAP_W         = calc_w(MAX_TAPS),
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLE_CYCLES = 8,
    parameter int unsigned MIN_WINDOW    = 4
) (
    input  logic                       i_fab_clk,
    input  logic                       i_arst_n,
    input  logic                       i_start,
    input  logic [NUM_LANES-1:0]       i_eye_monitor_early,
    input  logic [NUM_LANES-1:0]       i_eye_monitor_late,
    input  logic [NUM_LANES-1:0]       i_delay_line_out_of_range,
    output logic [NUM_LANES-1:0]       o_delay_line_load,
    output logic [NUM_LANES-1:0]       o_delay_line_move,
    output logic [NUM_LANES-1:0]       o_delay_line_direction,
    output logic [NUM_LANES-1:0]       o_eye_monitor_clear_flags,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [NUM_LANES-1:0]       o_lane_err,
    output logic [NUM_LANES*TAP_W-1:0] o_center_tap
);

    localparam int unsigned      LANE_W    = calc_w(NUM_LANES);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W:0]    MIN_WIN   = (TAP_W + 1)'(MIN_WINDOW);

    state_e                     r_state, w_state_d;
    logic [LANE_W-1:0]          r_lane;
    logic [TAP_W-1:0]           r_tap, r_left, r_right, r_center;
    logic                       r_found;
    logic [NUM_LANES-1:0]       r_lane_err;
    logic [NUM_LANES*TAP_W-1:0] r_center_tap;

    logic                 w_smp_start, w_smp_mode, w_smp_en, w_smp_done;
    logic                 w_fail_acc, w_oor_acc;
    logic                 w_eval_end, w_eval_fail, w_found_d, w_at_center, w_center_phase;
    logic [TAP_W-1:0]     w_left_d, w_right_d, w_center;
    logic [TAP_W:0]       w_window;
    logic [NUM_LANES-1:0] w_onehot;

    assign w_onehot       = NUM_LANES'(1) << r_lane;
    assign w_at_center    = (r_tap == r_center);
    assign w_center_phase = (r_state == StCenter) || (r_state == StCMove) ||
                            (r_state == StCSettle);
    assign w_center       = TAP_W'(({1'b0, r_left} + {1'b0, r_right}) >> 1);

    assign w_smp_mode  = (r_state == StClear);
    assign w_smp_en    = (r_state == StSample);
    assign w_smp_start = (r_state == StClear) || (r_state == StStep) ||
                         ((r_state == StCMove) && !w_at_center);

    ddr_eye_tap_sampler #(
        .NUM_LANES    (NUM_LANES),
        .LANE_W       (LANE_W),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .SAMPLE_CYCLES(SAMPLE_CYCLES)
    ) u_sampler (
        .i_clk        (i_fab_clk),
        .i_rst_n      (i_arst_n),
        .i_start      (w_smp_start),
        .i_mode_sample(w_smp_mode),
        .i_sample_en  (w_smp_en),
        .i_lane       (r_lane),
        .i_early      (i_eye_monitor_early),
        .i_late       (i_eye_monitor_late),
        .i_oor        (i_delay_line_out_of_range),
        .o_done       (w_smp_done),
        .o_fail_acc   (w_fail_acc),
        .o_oor_acc    (w_oor_acc)
    );

    // Tap evaluation in priority order; a lone passing last tap also ends the sweep.
    always_comb begin
        w_eval_end = 1'b0;
        w_found_d  = r_found;
        w_left_d   = r_left;
        w_right_d  = r_right;
        if (w_oor_acc) begin
            w_eval_end = 1'b1;
            if (r_found) w_right_d = r_tap - TAP_W'(1);
        end else if (!w_fail_acc && !r_found) begin
            w_found_d = 1'b1;
            w_left_d  = r_tap;
            if (r_tap == TAP_LAST) begin
                w_eval_end = 1'b1;
                w_right_d  = r_tap;
            end
        end else if (w_fail_acc && r_found) begin
            w_eval_end = 1'b1;
            w_right_d  = r_tap - TAP_W'(1);
        end else if (r_tap == TAP_LAST) begin
            w_eval_end = 1'b1;
            if (r_found && !w_fail_acc) w_right_d = r_tap;
        end
        w_window    = {1'b0, w_right_d} - {1'b0, w_left_d} + (TAP_W + 1)'(1);
        w_eval_fail = !w_found_d || (w_window < MIN_WIN);
    end

    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) r_state <= StIdle;
        else           r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (i_start) w_state_d = StLoad;
            StLoad:    w_state_d = StClear;
            StClear:   w_state_d = StSample;
            StSample:  if (w_smp_done) w_state_d = StEval;
            StEval: begin
                if (w_eval_end) w_state_d = w_eval_fail ? StFail : StCenter;
                else            w_state_d = StStep;
            end
            StStep:    w_state_d = StSettle;
            StSettle:  if (w_smp_done) w_state_d = StClear;
            StCenter:  w_state_d = StCMove;
            StCMove:   w_state_d = w_at_center ? StNext : StCSettle;
            StCSettle: if (w_smp_done) w_state_d = StCMove;
            StFail:    w_state_d = StNext;
            StNext:    w_state_d = (r_lane == LANE_LAST) ? StFinish : StLoad;
            StFinish:  w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_lane       <= '0;
            r_tap        <= '0;
            r_left       <= '0;
            r_right      <= '0;
            r_center     <= '0;
            r_found      <= 1'b0;
            r_lane_err   <= '0;
            r_center_tap <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_lane       <= '0;
                        r_lane_err   <= '0;
                        r_center_tap <= '0;
                    end
                end
                StLoad: begin
                    r_tap   <= '0;
                    r_found <= 1'b0;
                    r_left  <= '0;
                    r_right <= '0;
                end
                StEval: begin
                    r_found <= w_found_d;
                    r_left  <= w_left_d;
                    r_right <= w_right_d;
                end
                StStep:   r_tap <= r_tap + TAP_W'(1);
                StCenter: r_center <= w_center;
                StCMove: begin
                    if (w_at_center) begin
                        for (int unsigned i = 0; i < NUM_LANES; i++) begin
                            if (r_lane == LANE_W'(i)) begin
                                r_center_tap[tap_lsb(i, TAP_W) +: TAP_W] <= r_tap;
                            end
                        end
                    end else begin
                        r_tap <= r_tap - TAP_W'(1);
                    end
                end
                StFail: begin
                    r_tap <= '0;
                    for (int unsigned i = 0; i < NUM_LANES; i++) begin
                        if (r_lane == LANE_W'(i)) begin
                            r_lane_err[i]                            <= 1'b1;
                            r_center_tap[tap_lsb(i, TAP_W) +: TAP_W] <= '0;
                        end
                    end
                end
                StNext: if (r_lane != LANE_LAST) r_lane <= r_lane + LANE_W'(1);
                default: ;
            endcase
        end
    end

    assign o_delay_line_load         = ((r_state == StLoad) || (r_state == StFail)) ? w_onehot
                                                                                     : '0;
    assign o_delay_line_move         = ((r_state == StStep) ||
                                        ((r_state == StCMove) && !w_at_center)) ? w_onehot : '0;
    assign o_eye_monitor_clear_flags = (r_state == StClear) ? w_onehot : '0;
    // Idle lines rest at 0; while busy only the centring lane sees decrement.
    assign o_delay_line_direction    = (r_state == StIdle) ? '0 :
                                       (w_center_phase ? ~w_onehot : '1);
    assign o_busy                    = (r_state != StIdle);
    assign o_done                    = (r_state == StFinish);
    assign o_lane_err                = r_lane_err;
    assign o_center_tap              = r_center_tap;

endmodule
